// File: rtl/bram_sdp_clr_p.sv
// Simple-dual-port coefficient RAM with a sequential bulk-clear engine.
// Define BRAM_SDP_OUTREG_EN to add output registers (2-cycle read latency).
module bram_sdp_clr_p #(
  parameter int                DATA_W  = 18,
  parameter int                ADDR_W  = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_din,
  output logic [DATA_W-1:0] wr_dout,
  output logic [DATA_W-1:0] rd_dout
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic                done_nxt;
  logic                clr_done_p0;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_din;
  logic [ADDR_W-1:0]   reg_wra, reg_rda;
  logic [DATA_W-1:0]   ram [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      cnt         <= '0;
      clr_done_p0 <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      clr_done_p0 <= done_nxt;
    end
  end

  // The clear engine takes the write port outright; user writes are dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = wr_addr;
    mem_din   = wr_din;
    case (state)
      IDLE: begin
        mem_we = wr_en;
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_din  = CLR_VAL;
        cnt_nxt  = cnt + ADDR_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (!rst && mem_we) ram[mem_addr] <= mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wra <= '0;
      reg_rda <= '0;
    end else begin
      reg_wra <= wr_addr;
      reg_rda <= rd_addr;
    end
  end

`ifdef BRAM_SDP_OUTREG_EN
  logic [DATA_W-1:0] wr_dout_p1, rd_dout_p1;
  logic              clr_done_p1;

  // Output stage: array already holds the new word, so write-first survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_dout_p1  <= '0;
      rd_dout_p1  <= '0;
      clr_done_p1 <= 1'b0;
    end else begin
      wr_dout_p1  <= ram[reg_wra];
      rd_dout_p1  <= ram[reg_rda];
      clr_done_p1 <= clr_done_p0;
    end
  end

  assign wr_dout  = wr_dout_p1;
  assign rd_dout  = rd_dout_p1;
  assign clr_done = clr_done_p1;
`else
  assign wr_dout  = ram[reg_wra];
  assign rd_dout  = ram[reg_rda];
  assign clr_done = clr_done_p0;
`endif

endmodule

// File: tb/tb_bram_sdp_clr_p.sv
// Directed bench for bram_sdp_clr_p: default instance plus a 12x16 variant.
module tb_bram_sdp_clr_p;

`ifdef BRAM_SDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr_start, busy, clr_done, wr_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [17:0] wr_din, wr_dout, rd_dout;

  logic        rst2, clr_start2, busy2, clr_done2, wr_en2;
  logic [3:0]  wr_addr2, rd_addr2;
  logic [11:0] wr_din2, wr_dout2, rd_dout2;

  bram_sdp_clr_p dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_din(wr_din),
    .wr_dout(wr_dout), .rd_dout(rd_dout)
  );

  bram_sdp_clr_p #(.DATA_W(12), .ADDR_W(4), .CLR_VAL(12'hFFF)) dut2 (
    .clk(clk), .rst(rst2), .clr_start(clr_start2), .busy(busy2), .clr_done(clr_done2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .rd_addr(rd_addr2), .wr_din(wr_din2),
    .wr_dout(wr_dout2), .rd_dout(rd_dout2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n, pulses, bad;

  initial begin
    rst = 1'b1; clr_start = 1'b0; wr_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_din = '0;
    rst2 = 1'b1; clr_start2 = 1'b0; wr_en2 = 1'b0;
    wr_addr2 = '0; rd_addr2 = '0; wr_din2 = '0;

    // Reset clear
    repeat (3) tick();
    check("rst_busy", busy, 1);
    check("rst_done", clr_done, 0);
`ifdef BRAM_SDP_OUTREG_EN
    check("rst_rd_dout", rd_dout, 0);
    check("rst_wr_dout", wr_dout, 0);
`endif
    rst = 1'b0;
    n = 0;
    while (busy && n < 400) begin tick(); n++; end
    check("rst_clr_len", n, 256);
    if (LAT == 2) begin
      check("rst_done_early", clr_done, 0);
      tick();
    end
    check("rst_done_pulse", clr_done, 1);
    tick();
    check("rst_done_end", clr_done, 0);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      rd_addr = 8'(a); wr_addr = 8'(255 - a);
      repeat (LAT) tick();
      if (rd_dout !== 18'h0 || wr_dout !== 18'h0) bad++;
    end
    check("rst_clr_words", bad, 0);

    // Write then read
    wr_en = 1'b1; wr_addr = 8'h17; wr_din = 18'h2ABCD;
    tick();
    wr_en = 1'b0; rd_addr = 8'h17;
    repeat (LAT) tick();
    check("wr_rd_17", rd_dout, 18'h2ABCD);
    wr_en = 1'b1; wr_addr = 8'h30; wr_din = 18'h00005; rd_addr = 8'h30;
    tick();
    wr_en = 1'b0;
    repeat (LAT - 1) tick();
    check("collide_rd", rd_dout, 18'h00005);
    check("collide_wr", wr_dout, 18'h00005);
    check("collide_busy", busy, 0);
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 8'(8'hF0 + a); wr_din = 18'(18'h1000 * (a + 1) + a);
      tick();
    end
    wr_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 8'(8'hF0 + a);
      repeat (LAT) tick();
      check("burst_rd", rd_dout, 18'(18'h1000 * (a + 1) + a));
    end

    // Clear started alongside a user write, with blocked writes mid-clear
    clr_start = 1'b1; wr_en = 1'b1; wr_addr = 8'h40; wr_din = 18'h12345; rd_addr = 8'h40;
    tick();
    clr_start = 1'b0; wr_en = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      if (n == LAT - 1) check("clr_old_word", rd_dout, 18'h12345);
      wr_en = (n >= 10 && n < 20); wr_addr = 8'h05; wr_din = 18'h3FFFF;
      clr_start = (n == 50);
      tick(); n++;
    end
    wr_en = 1'b0; clr_start = 1'b0;
    check("clr_len", n, 256);
    repeat (LAT - 1) tick();
    check("clr_done", clr_done, 1);
    rd_addr = 8'h05; wr_addr = 8'h40;
    repeat (LAT) tick();
    check("blocked_wr", rd_dout, 0);
    check("cleared_40", wr_dout, 0);
    check("no_requeue", busy, 0);

    // Reset in the middle of a clear
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    pulses = 0;
    repeat (100) begin tick(); if (clr_done) pulses++; end
    rst = 1'b1;
    tick();
    check("mid_rst_busy", busy, 1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 400) begin tick(); n++; if (clr_done) pulses++; end
    check("mid_rst_len", n, 256);
    repeat (4) begin tick(); if (clr_done) pulses++; end
    check("mid_rst_pulses", pulses, 1);

    // Narrow/shallow variant
    tick();
    rst2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin tick(); n++; end
    check("v_clr_len", n, 16);
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      rd_addr2 = 4'(a);
      repeat (LAT) tick();
      if (rd_dout2 !== 12'hFFF) bad++;
    end
    check("v_clr_words", bad, 0);
    wr_en2 = 1'b1; wr_addr2 = 4'hF; wr_din2 = 12'h123;
    tick();
    wr_en2 = 1'b0; rd_addr2 = 4'hF;
    repeat (LAT) tick();
    check("v_rd_15", rd_dout2, 12'h123);
    check("v_wr_15", wr_dout2, 12'h123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_sdp_clr_p.md
Name: bram_sdp_clr_P

Overview:
- Parametrised simple-dual-port block RAM for NTT coefficient storage. One write port with write-side readback, one independent read port.
- Generalises the fixed 18x256 coefficient RAM to any width and depth.
- Adds a sequential bulk-clear engine, so a buffer is initialised to a known value after reset or between NTT passes without the controller issuing DEPTH writes.
- Sits between the NTT butterfly datapath and its address generator.

Parameters:
- DATA_W, 18, word width in bits (>=1).
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words (localparam, not overridable).
- CLR_VAL, 0, DATA_W-bit value written to every word by the clear engine.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous active-high reset.
- clr_start  in  1  request a bulk clear; sampled only in IDLE.
- busy  out  1  high while the clear engine owns the write port.
- clr_done  out  1  one-cycle pulse in the first cycle after a clear completes.
- wr_en  in  1  user write enable; ignored while busy.
- wr_addr  in  ADDR_W  write / write-readback address.
- rd_addr  in  ADDR_W  read address.
- wr_din  in  DATA_W  write data.
- wr_dout  out  DATA_W  ram[registered wr_addr].
- rd_dout  out  DATA_W  ram[registered rd_addr].

Behaviour:
- Storage: DEPTH x DATA_W array, no reset on the array itself. Written only on a clk edge.
- Address registers: reg_wra <= wr_addr and reg_rda <= rd_addr every cycle, including while busy. Both reset to 0.
- Read outputs: wr_dout = ram[reg_wra] and rd_dout = ram[reg_rda], combinational from the array.
- Read latency: 1 cycle from address to data.
- Write/read collision: user write to A at edge T with rd_addr=A sampled at the same edge -> rd_dout shows the new data after T (write-first). wr_dout behaves the same way for wr_addr.
- FSM states are IDLE and CLEAR, with counter cnt[ADDR_W-1:0].
- While rst is high: state=CLEAR, cnt=0, busy=1, clr_done=0, no array write. Reset therefore always triggers an automatic clear.
- CLEAR state, each edge with rst low:
  - ram[cnt] <= CLR_VAL; cnt <= cnt+1.
  - When cnt==DEPTH-1: go to IDLE, cnt wraps to 0, clr_done=1 for the next cycle.
  - A clear takes exactly DEPTH cycles. busy is low in the cycle clr_done is high.
- IDLE state:
  - wr_en=1 -> ram[wr_addr] <= wr_din.
  - clr_start=1 -> next state CLEAR with cnt=0. If wr_en=1 in the same cycle, the user write still completes at that edge.
- clr_start while busy: ignored, not queued.
- wr_en while busy: dropped, not queued.
- busy = (state==CLEAR), registered-state decode.
- Reads during CLEAR are permitted. They return CLR_VAL for already-cleared words and the old contents otherwise.
- Reset mid-clear: restarts the sweep from address 0; the full DEPTH cycles are needed again.
- Output reset values: busy=1, clr_done=0. rd_dout and wr_dout are unspecified while rst is high and in the first cycle after release; from then on they show CLR_VAL (address regs=0, word 0 cleared).

Optional Feature:
- Macro: BRAM_SDP_OUTREG_EN.
- Defined: rd_dout and wr_dout are additionally registered, giving 2-cycle address-to-data latency.
  - Output registers reset to 0 with rst.
  - Write-first collision semantics are kept, one cycle later.
  - clr_done is delayed by one cycle, so it aligns with the last cleared word being visible.
- Undefined: 1-cycle latency as above, with no output registers.

Test Plan:
- Reset clear (defaults):
  - Stimulus: rst high 3 cycles, then low.
  - Required: busy=1 for exactly 256 cycles after release; clr_done pulses at cycle 257; reading addresses 0..255 afterwards returns 0.
- Write/read:
  - Stimulus: in IDLE, write 0x2ABCD to address 0x17, then set rd_addr=0x17.
  - Required: rd_dout=0x2ABCD one cycle later. Same-cycle write 0x00005 to 0x30 with rd_addr=0x30 -> rd_dout=0x00005 the next cycle.
- Write blocked while busy:
  - Stimulus: clr_start pulse, then wr_en=1, wr_addr=0x05, wr_din=0x3FFFF during the clear.
  - Required: after clr_done, address 0x05 reads 0; a clr_start issued mid-clear does not extend busy beyond 256 cycles.
- Reset mid-clear:
  - Stimulus: rst asserted for 1 cycle at clear cycle 100.
  - Required: busy stays high for 256 further cycles; clr_done pulses exactly once.
- Parameter variant DATA_W=12, ADDR_W=4, CLR_VAL=12'hFFF:
  - Required: the clear lasts 16 cycles and every word reads 0xFFF. Write 0x123 to address 15 then read it back -> 0x123.
- BRAM_SDP_OUTREG_EN defined:
  - Stimulus: repeat the write/read test.
  - Required: data appears 2 cycles after the address; outputs read 0 during rst.
